// File: rtl/bus_c_write_back.sv
// rtl/bus_c_write_back.sv - BUS_C write-back into architectural registers and RAM write handshake
// Optional BUS_C_RAM_TIMEOUT_EN: abandon a RAM request after 16 cycles without acknowledge.
module bus_c_write_back #(
  parameter int DATA_W = 16,
  parameter int RAM_W  = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] BUS_C,
  input  logic              WRITE_EN,
  input  logic [2:0]        WRITE_SEL,
  input  logic              INC_PC,
  input  logic              INC_R1,
  input  logic              INC_AC,
  input  logic              CLR_AC,
  input  logic              RAM_WRITE_ACK,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] TR,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] AC,
  output logic [RAM_W-1:0]  IR,
  output logic              RAM_WRITE_REQ,
  output logic [RAM_W-1:0]  RAM_WRITE_DATA,
  output logic              BUSY,
  output logic              Z,
  output logic              ERR
);

  // Same code map as the bus-B multiplexer select.
  localparam logic [2:0] SEL_RAM = 3'd0;
  localparam logic [2:0] SEL_PC  = 3'd1;
  localparam logic [2:0] SEL_R1  = 3'd2;
  localparam logic [2:0] SEL_R2  = 3'd3;
  localparam logic [2:0] SEL_TR  = 3'd4;
  localparam logic [2:0] SEL_R   = 3'd5;
  localparam logic [2:0] SEL_AC  = 3'd6;
  localparam logic [2:0] SEL_IR  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            state;
  logic              req_q;
  logic              wr_ram;
  logic [DATA_W-1:0] ac_next;
`ifdef BUS_C_RAM_TIMEOUT_EN
  logic [3:0]        req_cnt;
`endif

  assign wr_ram = WRITE_EN && (WRITE_SEL == SEL_RAM);

  // AC next value is shared by the AC register and the registered zero flag.
  always_comb begin
    ac_next = AC;
    if (WRITE_EN && (WRITE_SEL == SEL_AC)) begin
      ac_next = BUS_C;
    end else if (CLR_AC) begin
      ac_next = '0;
    end else if (INC_AC) begin
      ac_next = AC + DATA_W'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      PC <= '0;
      R1 <= '0;
      R2 <= '0;
      TR <= '0;
      R  <= '0;
      AC <= '0;
      IR <= '0;
      Z  <= 1'b1;
    end else begin
      if (WRITE_EN && (WRITE_SEL == SEL_PC)) begin
        PC <= BUS_C;
      end else if (INC_PC) begin
        PC <= PC + DATA_W'(1);
      end
      if (WRITE_EN && (WRITE_SEL == SEL_R1)) begin
        R1 <= BUS_C;
      end else if (INC_R1) begin
        R1 <= R1 + DATA_W'(1);
      end
      if (WRITE_EN && (WRITE_SEL == SEL_R2)) begin
        R2 <= BUS_C;
      end
      if (WRITE_EN && (WRITE_SEL == SEL_TR)) begin
        TR <= BUS_C;
      end
      if (WRITE_EN && (WRITE_SEL == SEL_R)) begin
        R <= BUS_C;
      end
      if (WRITE_EN && (WRITE_SEL == SEL_IR)) begin
        IR <= BUS_C[RAM_W-1:0];
      end
      AC <= ac_next;
      Z  <= (ac_next == '0);
    end
  end

  // RAM write handshake; a RAM write arriving while one is outstanding is dropped and flagged.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state          <= ST_IDLE;
      req_q          <= 1'b0;
      RAM_WRITE_DATA <= '0;
      ERR            <= 1'b0;
`ifdef BUS_C_RAM_TIMEOUT_EN
      req_cnt        <= 4'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_ram) begin
            RAM_WRITE_DATA <= BUS_C[RAM_W-1:0];
            state          <= ST_REQ;
            req_q          <= 1'b1;
`ifdef BUS_C_RAM_TIMEOUT_EN
            req_cnt        <= 4'd0;
`endif
          end
        end
        ST_REQ: begin
          if (wr_ram) begin
            ERR <= 1'b1;
          end
          if (RAM_WRITE_ACK) begin
            state <= ST_IDLE;
            req_q <= 1'b0;
`ifdef BUS_C_RAM_TIMEOUT_EN
          end else if (req_cnt == 4'hF) begin
            state <= ST_IDLE;
            req_q <= 1'b0;
            ERR   <= 1'b1;
          end else begin
            req_cnt <= req_cnt + 4'd1;
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign RAM_WRITE_REQ = req_q;
  assign BUSY          = req_q;

endmodule

// File: tb/tb_bus_c_write_back.sv
// tb/tb_bus_c_write_back.sv - directed scoreboard bench for bus_c_write_back
// Follows BUS_C_RAM_TIMEOUT_EN the same way as the design.
module tb_bus_c_write_back;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [15:0] BUS_C;
  logic        WRITE_EN;
  logic [2:0]  WRITE_SEL;
  logic        INC_PC, INC_R1, INC_AC, CLR_AC, RAM_WRITE_ACK;
  logic [15:0] PC, R1, R2, TR, R, AC;
  logic [7:0]  IR, RAM_WRITE_DATA;
  logic        RAM_WRITE_REQ, BUSY, Z, ERR;

  bus_c_write_back #(.DATA_W(16), .RAM_W(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .BUS_C(BUS_C), .WRITE_EN(WRITE_EN),
    .WRITE_SEL(WRITE_SEL), .INC_PC(INC_PC), .INC_R1(INC_R1), .INC_AC(INC_AC),
    .CLR_AC(CLR_AC), .RAM_WRITE_ACK(RAM_WRITE_ACK), .PC(PC), .R1(R1), .R2(R2),
    .TR(TR), .R(R), .AC(AC), .IR(IR), .RAM_WRITE_REQ(RAM_WRITE_REQ),
    .RAM_WRITE_DATA(RAM_WRITE_DATA), .BUSY(BUSY), .Z(Z), .ERR(ERR)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [15:0] pc, r1, r2, tr, r, ac;
    logic [7:0]  ir, data;
    logic        req, busy, z, err;
  } snap_t;

  snap_t sb[$];
  snap_t m;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic we, input logic [2:0] sel, input logic [15:0] c);
    WRITE_EN  = we;
    WRITE_SEL = sel;
    BUS_C     = c;
  endtask

  task automatic reset_model();
    m = '{default: '0};
    m.z = 1'b1;
  endtask

  // Expected state is queued at drive time and retired after the next rising edge.
  task automatic push_step(input string tag);
    snap_t e;
    sb.push_back(m);
    @(posedge CLOCK);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, PC, e.pc);
    chk({tag, ".r1"}, R1, e.r1);
    chk({tag, ".r2"}, R2, e.r2);
    chk({tag, ".tr"}, TR, e.tr);
    chk({tag, ".r"}, R, e.r);
    chk({tag, ".ac"}, AC, e.ac);
    chk({tag, ".ir"}, {8'h00, IR}, {8'h00, e.ir});
    chk({tag, ".data"}, {8'h00, RAM_WRITE_DATA}, {8'h00, e.data});
    chk({tag, ".req"}, {15'h0, RAM_WRITE_REQ}, {15'h0, e.req});
    chk({tag, ".busy"}, {15'h0, BUSY}, {15'h0, e.busy});
    chk({tag, ".z"}, {15'h0, Z}, {15'h0, e.z});
    chk({tag, ".err"}, {15'h0, ERR}, {15'h0, e.err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; drv(1'b0, 3'd0, 16'h0);
    INC_PC = 0; INC_R1 = 0; INC_AC = 0; CLR_AC = 0; RAM_WRITE_ACK = 0;
    reset_model();
    @(posedge CLOCK); #1;
    push_step("reset");
    RESET = 1'b0;

    drv(1, 3'd1, 16'h1080); m.pc = 16'h1080; push_step("wr_pc");
    drv(1, 3'd6, 16'h00C0); m.ac = 16'h00C0; m.z = 0; push_step("wr_ac");
    drv(1, 3'd1, 16'hFFFF); m.pc = 16'hFFFF; push_step("pc_ffff");
    drv(0, 3'd0, 16'h0); INC_PC = 1; m.pc = 16'h0000; push_step("pc_wrap");
    drv(1, 3'd1, 16'h0005); m.pc = 16'h0005; push_step("pc_load_over_inc");
    INC_PC = 0;
    drv(1, 3'd2, 16'h1234); m.r1 = 16'h1234; push_step("wr_r1");
    drv(0, 3'd0, 16'h0); INC_R1 = 1; m.r1 = 16'h1235; push_step("inc_r1");
    INC_R1 = 0;
    drv(1, 3'd3, 16'hBEEF); m.r2 = 16'hBEEF; push_step("wr_r2");
    drv(1, 3'd4, 16'h0F0F); m.tr = 16'h0F0F; push_step("wr_tr");
    drv(1, 3'd5, 16'hA5A5); m.r = 16'hA5A5; push_step("wr_r");
    drv(1, 3'd7, 16'h12C3); m.ir = 8'hC3; push_step("wr_ir");

    drv(1, 3'd6, 16'h0001); m.ac = 16'h0001; m.z = 0; push_step("ac_one");
    drv(0, 3'd0, 16'h0); CLR_AC = 1; INC_AC = 1; m.ac = 16'h0; m.z = 1; push_step("clr_over_inc");
    drv(1, 3'd6, 16'h0077); m.ac = 16'h0077; m.z = 0; push_step("load_over_clr");
    CLR_AC = 0;
    drv(0, 3'd0, 16'h0); m.ac = 16'h0078; push_step("inc_ac");
    drv(1, 3'd6, 16'hFFFF); m.ac = 16'hFFFF; push_step("load_over_inc_ac");
    drv(0, 3'd0, 16'h0); m.ac = 16'h0000; m.z = 1; push_step("ac_wrap");
    INC_AC = 0;

    drv(1, 3'd0, 16'hAB55); m.req = 1; m.busy = 1; m.data = 8'h55; push_step("ram_c1");
    drv(0, 3'd0, 16'h0);
    push_step("ram_c2");
    push_step("ram_c3");
    push_step("ram_c4");
    RAM_WRITE_ACK = 1; m.req = 0; m.busy = 0; push_step("ram_ack");
    push_step("ack_idle_ignored");
    RAM_WRITE_ACK = 0;

    drv(1, 3'd0, 16'h1255); m.req = 1; m.busy = 1; m.data = 8'h55; push_step("ram2_start");
    drv(1, 3'd0, 16'h0077); m.err = 1; push_step("ram2_drop");
    drv(1, 3'd7, 16'h0077); m.ir = 8'h77; push_step("ir_while_busy");
    drv(0, 3'd0, 16'h0); RAM_WRITE_ACK = 1; m.req = 0; m.busy = 0; push_step("ram2_ack");
    RAM_WRITE_ACK = 0;

    drv(1, 3'd0, 16'h00AA); m.req = 1; m.busy = 1; m.data = 8'hAA; push_step("b2b_first");
    drv(0, 3'd0, 16'h0); RAM_WRITE_ACK = 1; m.req = 0; m.busy = 0; push_step("b2b_min_len");
    RAM_WRITE_ACK = 0;
    drv(1, 3'd0, 16'h003C); m.req = 1; m.busy = 1; m.data = 8'h3C; push_step("b2b_second");
    drv(0, 3'd0, 16'h0); RAM_WRITE_ACK = 1; m.req = 0; m.busy = 0; push_step("b2b_ack");
    RAM_WRITE_ACK = 0;

    drv(1, 3'd0, 16'h0011); m.req = 1; m.busy = 1; m.data = 8'h11; push_step("abort_start");
    drv(0, 3'd0, 16'h0); RESET = 1; reset_model(); push_step("abort_reset");
    RESET = 0;

    drv(1, 3'd0, 16'h0022); m.req = 1; m.busy = 1; m.data = 8'h22; push_step("ackdrop_start");
    drv(1, 3'd0, 16'h0033); RAM_WRITE_ACK = 1;
    m.req = 0; m.busy = 0; m.err = 1; push_step("ackdrop");
    RAM_WRITE_ACK = 0; drv(0, 3'd0, 16'h0);
    RESET = 1; reset_model(); push_step("reset2");
    RESET = 0;

    drv(1, 3'd0, 16'h0099); m.req = 1; m.busy = 1; m.data = 8'h99; push_step("hold_c1");
    drv(0, 3'd0, 16'h0);
`ifdef BUS_C_RAM_TIMEOUT_EN
    repeat (15) push_step("hold_req");
    m.req = 0; m.busy = 0; m.err = 1; push_step("timeout");
`else
    repeat (99) push_step("hold_req");
    RAM_WRITE_ACK = 1; m.req = 0; m.busy = 0; push_step("hold_ack");
    RAM_WRITE_ACK = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
